// File: rtl/inst_queue_if.sv
// inst_queue_if: Fetch -> queue -> Decode signal bundle for inst_queue.
//   slave  : queue side (takes fetch slots, decode_pop and flush; drives buffer_*)
//   master : environment side (Fetch/Decode/Commit)
// Fetch side : fetch_valid0/1, fetch_PC0/1, fetch_inst0/1, fetch_predict0/1,
//              fetch_predict_target0/1, fetch_excode0/1, fetch_RAS, fetch_output_en
// Decode side: decode_pop, buffer_valid0/1 and the fields of head / head+1,
//              buffer_count, buffer_ready
// Commit side: flush
interface inst_queue_if #(
  parameter int DEPTH = 16,
  parameter int EXC_W = 5,
  parameter int RAS_W = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             fetch_valid0;
  logic             fetch_valid1;
  logic [31:0]      fetch_PC0;
  logic [31:0]      fetch_PC1;
  logic [31:0]      fetch_inst0;
  logic [31:0]      fetch_inst1;
  logic             fetch_predict0;
  logic             fetch_predict1;
  logic [31:0]      fetch_predict_target0;
  logic [31:0]      fetch_predict_target1;
  logic [EXC_W-1:0] fetch_excode0;
  logic [EXC_W-1:0] fetch_excode1;
  logic [RAS_W-1:0] fetch_RAS;
  logic             fetch_output_en;
  logic             buffer_ready;
  logic             flush;
  logic [1:0]       decode_pop;
  logic             buffer_valid0;
  logic             buffer_valid1;
  logic [31:0]      buffer_PC0;
  logic [31:0]      buffer_PC1;
  logic [31:0]      buffer_inst0;
  logic [31:0]      buffer_inst1;
  logic             buffer_predict0;
  logic             buffer_predict1;
  logic [31:0]      buffer_predict_target0;
  logic [31:0]      buffer_predict_target1;
  logic [EXC_W-1:0] buffer_excode0;
  logic [EXC_W-1:0] buffer_excode1;
  logic [RAS_W-1:0] buffer_RAS0;
  logic [RAS_W-1:0] buffer_RAS1;
  logic [CW-1:0]    buffer_count;

  modport slave (
    input  fetch_valid0, fetch_valid1, fetch_PC0, fetch_PC1, fetch_inst0, fetch_inst1,
           fetch_predict0, fetch_predict1, fetch_predict_target0, fetch_predict_target1,
           fetch_excode0, fetch_excode1, fetch_RAS, fetch_output_en, flush, decode_pop,
    output buffer_ready, buffer_valid0, buffer_valid1, buffer_PC0, buffer_PC1,
           buffer_inst0, buffer_inst1, buffer_predict0, buffer_predict1,
           buffer_predict_target0, buffer_predict_target1, buffer_excode0, buffer_excode1,
           buffer_RAS0, buffer_RAS1, buffer_count
  );

  modport master (
    output fetch_valid0, fetch_valid1, fetch_PC0, fetch_PC1, fetch_inst0, fetch_inst1,
           fetch_predict0, fetch_predict1, fetch_predict_target0, fetch_predict_target1,
           fetch_excode0, fetch_excode1, fetch_RAS, fetch_output_en, flush, decode_pop,
    input  buffer_ready, buffer_valid0, buffer_valid1, buffer_PC0, buffer_PC1,
           buffer_inst0, buffer_inst1, buffer_predict0, buffer_predict1,
           buffer_predict_target0, buffer_predict_target1, buffer_excode0, buffer_excode1,
           buffer_RAS0, buffer_RAS1, buffer_count
  );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: per-instruction circular queue between Fetch and Decode.
// Fetch pushes 0-2 instructions per cycle (invalid slots compacted out),
// Decode pops 0-2 per cycle, Commit flush empties it in one cycle.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   resetn : synchronous active-low reset
//   bus    : inst_queue_if.slave (fetch slots, decode_pop, flush, buffer_* outputs)
module inst_queue #(
  parameter int DEPTH = 16,
  parameter int EXC_W = 5,
  parameter int RAS_W = 64
) (
  input  logic        clk,
  input  logic        resetn,
  inst_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic             predict;
    logic [31:0]      target;
    logic [EXC_W-1:0] excode;
    logic [RAS_W-1:0] ras;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          ready;
  logic          push_ok;
  logic [1:0]    n_in;
  logic [1:0]    pop_req;
  logic [1:0]    n_out;
  logic          wr0_en, wr1_en;
  entry_t        slot0, slot1, wr0_data;
  logic [PW-1:0] head_p1;

  // Room for a full pair is required before Fetch may push at all.
  assign ready   = (count_q <= CW'(DEPTH - 2));
  assign push_ok = bus.fetch_output_en & ready & ~bus.flush & resetn;
  assign head_p1 = head_q + PW'(1);

  assign slot0 = '{pc: bus.fetch_PC0, inst: bus.fetch_inst0, predict: bus.fetch_predict0,
                   target: bus.fetch_predict_target0, excode: bus.fetch_excode0,
                   ras: bus.fetch_RAS};
  assign slot1 = '{pc: bus.fetch_PC1, inst: bus.fetch_inst1, predict: bus.fetch_predict1,
                   target: bus.fetch_predict_target1, excode: bus.fetch_excode1,
                   ras: bus.fetch_RAS};

  // Push compaction: the first valid slot always lands at tail.
  always_comb begin
    n_in     = 2'd0;
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_data = slot0;
    if (push_ok) begin
      case ({bus.fetch_valid1, bus.fetch_valid0})
        2'b11: begin
          n_in   = 2'd2;
          wr0_en = 1'b1;
          wr1_en = 1'b1;
        end
        2'b10: begin
          n_in     = 2'd1;
          wr0_en   = 1'b1;
          wr0_data = slot1;
        end
        2'b01: begin
          n_in   = 2'd1;
          wr0_en = 1'b1;
        end
        default: begin
          n_in = 2'd0;
        end
      endcase
    end else begin
      n_in = 2'd0;
    end
  end

  // Pop amount: decode_pop=3 means 2, and never more than the pre-push count.
  always_comb begin
    case (bus.decode_pop)
      2'd0:    pop_req = 2'd0;
      2'd1:    pop_req = 2'd1;
      default: pop_req = 2'd2;
    endcase
    if (CW'(pop_req) > count_q) begin
      n_out = count_q[1:0];
    end else begin
      n_out = pop_req;
    end
  end

  // Next-state pointers and occupancy; flush discards same-cycle push/pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      head_d  = head_q + PW'(n_out);
      tail_d  = tail_q + PW'(n_in);
      count_d = count_q + CW'(n_in) - CW'(n_out);
    end
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; not cleared on reset or flush, pointers make it invisible.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      mem_q[tail_q] <= wr0_data;
    end
    if (wr1_en) begin
      mem_q[tail_q + PW'(1)] <= slot1;
    end
  end

  assign bus.buffer_ready           = ready;
  assign bus.buffer_count           = count_q;
  assign bus.buffer_valid0          = (count_q != {CW{1'b0}});
  assign bus.buffer_valid1          = (count_q >= CW'(2));
  assign bus.buffer_PC0             = mem_q[head_q].pc;
  assign bus.buffer_inst0           = mem_q[head_q].inst;
  assign bus.buffer_predict0        = mem_q[head_q].predict;
  assign bus.buffer_predict_target0 = mem_q[head_q].target;
  assign bus.buffer_excode0         = mem_q[head_q].excode;
  assign bus.buffer_RAS0            = mem_q[head_q].ras;
  assign bus.buffer_PC1             = mem_q[head_p1].pc;
  assign bus.buffer_inst1           = mem_q[head_p1].inst;
  assign bus.buffer_predict1        = mem_q[head_p1].predict;
  assign bus.buffer_predict_target1 = mem_q[head_p1].target;
  assign bus.buffer_excode1         = mem_q[head_p1].excode;
  assign bus.buffer_RAS1            = mem_q[head_p1].ras;
endmodule

// File: doc/inst_queue.md
# inst_queue

Per-instruction circular instruction queue between Fetch and Decode, replacing the fixed pair-granular buffer. Fetch pushes 0–2 instructions per cycle; invalid slots are compacted out. Decode pops 0–2 per cycle. Depth, exception-code width and RAS-snapshot width are parameters, and the queue reports its exact occupancy. A commit-side flush empties it in one cycle.

## Interface
Parameters:
- DEPTH, 16, number of instruction entries; power of two, ≥4
- EXC_W, 5, exception-code width
- RAS_W, 64, RAS snapshot width; stored per entry

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- fetch_valid0 / fetch_valid1  in  1 each  slot valid
- fetch_PC0 / fetch_PC1  in  32 each  instruction address
- fetch_inst0 / fetch_inst1  in  32 each  instruction word
- fetch_predict0 / fetch_predict1  in  1 each  predicted taken
- fetch_predict_target0 / fetch_predict_target1  in  32 each  predicted target
- fetch_excode0 / fetch_excode1  in  EXC_W each  fetch exception code
- fetch_RAS  in  RAS_W  RAS snapshot shared by both slots
- fetch_output_en  in  1  push request
- buffer_ready  out  1  free entries ≥ 2; Fetch pushes only when high
- flush  in  1  empty queue (from Commit)
- decode_pop  in  2  instructions Decode consumes this cycle (0,1,2)
- buffer_valid0 / buffer_valid1  out  1 each  head / head+1 entry present
- buffer_PC0/1, buffer_inst0/1, buffer_predict0/1, buffer_predict_target0/1, buffer_excode0/1, buffer_RAS0/1  out  same widths  fields of head / head+1 entry
- buffer_count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- State: head and tail pointers ($clog2(DEPTH) bits, wrap modulo DEPTH), count register, entry storage {PC, inst, predict, target, excode, RAS}.
- Push accepted when fetch_output_en & buffer_ready & ~flush. n_in = fetch_valid0 + fetch_valid1.
  - Both valid: slot0 written to tail, slot1 to tail+1.
  - Only slot1 valid: slot1 written to tail (compaction).
  - Only slot0 valid: slot0 written to tail.
  - Both copies of the entry receive fetch_RAS.
  - tail += n_in.
- Pop: n_out = min(decode_pop, count), using pre-push count. Values of decode_pop above count are clamped, never underflow. decode_pop=3 is treated as 2. head += n_out.
- count_next = count + n_in − n_out. Push and pop in the same cycle are both honoured.
- Outputs are combinational reads: buffer_valid0 = count≥1, buffer_valid1 = count≥2. Slot-0 fields come from entry[head], slot-1 fields from entry[head+1 mod DEPTH]. Field values are don't-care when the matching valid is 0.
- buffer_ready = (DEPTH − count) ≥ 2, combinational from the count register.
- flush: head, tail and count go to 0 next cycle. Any same-cycle push and pop are discarded. Storage is not cleared.
- Reset (resetn=0 at edge): head=tail=count=0. Same priority as flush; overrides everything.

## Timing
- Reset values: buffer_valid0=0, buffer_valid1=0, buffer_count=0, buffer_ready=1. Data outputs are don't-care.
- Push-to-visible latency is 1 cycle. An instruction pushed at edge k appears on buffer_* after edge k. There is no same-cycle bypass from fetch to decode.
- Pop takes effect at the edge. The next entries are presented in the following cycle.
- Full boundary: at count=DEPTH−1 or DEPTH, buffer_ready=0 and a push request is ignored. Pops still proceed.
- Empty boundary: at count=0, buffer_valid0=buffer_valid1=0 and decode_pop is ignored.
- Wrap-around: a two-entry push with tail=DEPTH−1 writes entries DEPTH−1 and 0. A two-entry pop with head=DEPTH−1 reads the same wrapped pair.
- Flush and reset in the same cycle as a push or pop: both win, and the queue is empty next cycle.

## Test plan
- Reset, then push both slots with PC 0x1000/0x1004 and decode_pop=0. Next cycle: valid0=valid1=1, PC0=0x1000, PC1=0x1004, count=2.
- Push with only fetch_valid1=1 (PC 0x2004) into an empty queue. Next cycle: valid0=1, PC0=0x2004, valid1=0, count=1.
- DEPTH=16: fill to 14 with pairs, then push again. ready=1 at count 14, the push succeeds, and at count 16 ready=0. A further push is ignored and count stays 16.
- Count=1 with decode_pop=2 and a simultaneous two-valid push. Next cycle count=2, and head points at the first newly pushed instruction.
- Cycle pushes and pops past wrap-around (≥40 instructions with sequential PCs, random decode_pop). PCs pop out in strict order with no loss or duplication.
- Count=9 with simultaneous flush, push and decode_pop=2. Next cycle count=0, valid0=0 and ready=1. Then a push of 0x3000 appears as PC0 one cycle after it.
